// File: rtl/rf_wr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// RF_my_pkg -- shared definitions for the register-file write arbiter.
//   WD         : write-data width (also the width of the one-hot write vector)
//   SEL        : register address width
//   wr_state_e : write-port FSM states (IDLE = nothing held, ISSUE = one write
//                held in the output register)
// -----------------------------------------------------------------------------
package RF_my_pkg;

  localparam int unsigned WD  = 32;
  localparam int unsigned SEL = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } wr_state_e;

endpackage

// File: rtl/rf_wr_arbiter_rr_arb.sv
// -----------------------------------------------------------------------------
// rf_rr_arb -- two-requester round-robin arbiter (purely combinational).
//   en_i     : acceptance allowed this cycle
//   valid0_i : requester 0 pending
//   valid1_i : requester 1 pending
//   ptr_i    : round-robin pointer (0 favours requester 0, 1 favours 1)
//   gnt0_o   : requester 0 granted
//   gnt1_o   : requester 1 granted
//   ptr_d_o  : next pointer value (points away from the requester just granted)
// -----------------------------------------------------------------------------
module rf_rr_arb (
  input  logic en_i,
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic ptr_i,
  output logic gnt0_o,
  output logic gnt1_o,
  output logic ptr_d_o
);

  // Grant selection: a lone requester always wins, a tie goes to the pointer.
  always_comb begin
    gnt0_o  = 1'b0;
    gnt1_o  = 1'b0;
    ptr_d_o = ptr_i;
    if (!en_i) begin
      gnt0_o = 1'b0;
      gnt1_o = 1'b0;
    end else if (valid0_i && valid1_i) begin
      gnt0_o = (ptr_i == 1'b0);
      gnt1_o = (ptr_i == 1'b1);
    end else begin
      gnt0_o = valid0_i;
      gnt1_o = valid1_i;
    end

    // After any acceptance the other requester becomes favoured.
    if (gnt0_o) begin
      ptr_d_o = 1'b1;
    end else if (gnt1_o) begin
      ptr_d_o = 1'b0;
    end else begin
      ptr_d_o = ptr_i;
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wr_arbiter -- arbitrates two register-write requesters onto one register
// file write port with a single-entry output register.
//
// Parameters : WD (data / one-hot width), SEL (address width), CW (counter width)
// Ports
//   clk, rst                      : clock, synchronous active-high reset
//   req{0,1}_valid/addr/data      : requester write requests
//   req{0,1}_ready                : request accepted this cycle (combinational)
//   rf_stall                      : register file cannot take a write
//   wr_en/wr_addr/wr_data         : registered write port
//   wr_onehot                     : decoded wr_addr, zero when idle or addr 0
//   wr_count                      : saturating completed-write counter
// Optional (macro RF_WR_FWD_EN)
//   rd_addr, fwd_hit, fwd_data    : bypass of the held write to a reader
// Writes to register 0 are acknowledged and dropped.
// -----------------------------------------------------------------------------
module rf_wr_arbiter #(
  parameter int unsigned WD  = RF_my_pkg::WD,
  parameter int unsigned SEL = RF_my_pkg::SEL,
  parameter int unsigned CW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic [SEL-1:0] req0_addr,
  input  logic [WD-1:0]  req0_data,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [SEL-1:0] req1_addr,
  input  logic [WD-1:0]  req1_data,
  output logic           req1_ready,
  input  logic           rf_stall,
`ifdef RF_WR_FWD_EN
  input  logic [SEL-1:0] rd_addr,
  output logic           fwd_hit,
  output logic [WD-1:0]  fwd_data,
`endif
  output logic           wr_en,
  output logic [SEL-1:0] wr_addr,
  output logic [WD-1:0]  wr_data,
  output logic [WD-1:0]  wr_onehot,
  output logic [CW-1:0]  wr_count
);

  import RF_my_pkg::*;

  // One-hot decode of a register address; address 0 decodes to all-zero.
  function automatic logic [WD-1:0] decode_addr(input logic [SEL-1:0] addr);
    logic [WD-1:0] dec;
    dec = '0;
    for (int i = 0; i < int'(WD); i++) begin
      if ((i != 0) && (int'(addr) == i)) begin
        dec[i] = 1'b1;
      end else begin
        dec[i] = 1'b0;
      end
    end
    return dec;
  endfunction

  wr_state_e      state_q, state_d;
  logic           ptr_q, ptr_d;
  logic [SEL-1:0] addr_q, addr_d;
  logic [WD-1:0]  data_q, data_d;
  logic [WD-1:0]  onehot_q, onehot_d;
  logic [CW-1:0]  count_q, count_d;

  logic           complete_s;
  logic           accept_en_s;
  logic           gnt0_s, gnt1_s;
  logic           accept_s;
  logic [SEL-1:0] acc_addr_s;
  logic [WD-1:0]  acc_data_s;

  // A held write leaves the port whenever the register file is not stalled.
  assign complete_s  = (state_q == ISSUE) && !rf_stall;
  // The output register is free when empty or draining this cycle.
  assign accept_en_s = !rst && ((state_q == IDLE) || complete_s);

  rf_rr_arb u_arb (
    .en_i     (accept_en_s),
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .ptr_i    (ptr_q),
    .gnt0_o   (gnt0_s),
    .gnt1_o   (gnt1_s),
    .ptr_d_o  (ptr_d)
  );

  assign req0_ready = gnt0_s;
  assign req1_ready = gnt1_s;
  assign accept_s   = gnt0_s || gnt1_s;
  assign acc_addr_s = gnt1_s ? req1_addr : req0_addr;
  assign acc_data_s = gnt1_s ? req1_data : req0_data;

  // Next-state and output-register load logic.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    onehot_d = onehot_q;
    count_d  = count_q;

    case (state_q)
      IDLE: begin
        if (accept_s && (acc_addr_s != '0)) begin
          state_d  = ISSUE;
          addr_d   = acc_addr_s;
          data_d   = acc_data_s;
          onehot_d = decode_addr(acc_addr_s);
        end else begin
          state_d  = IDLE;
        end
      end
      ISSUE: begin
        if (complete_s && accept_s && (acc_addr_s != '0)) begin
          state_d  = ISSUE;
          addr_d   = acc_addr_s;
          data_d   = acc_data_s;
          onehot_d = decode_addr(acc_addr_s);
        end else if (complete_s) begin
          // Drained with nothing new (or only a discarded addr-0 request).
          state_d  = IDLE;
          onehot_d = '0;
        end else begin
          state_d  = ISSUE;
        end
      end
      default: begin
        state_d  = IDLE;
        onehot_d = '0;
      end
    endcase

    if (complete_s && !(&count_q)) begin
      count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // State and output registers; reset drops any held write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      onehot_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      onehot_q <= onehot_d;
      count_q  <= count_d;
    end
  end

  assign wr_en     = (state_q == ISSUE);
  assign wr_addr   = addr_q;
  assign wr_data   = data_q;
  assign wr_onehot = onehot_q;
  assign wr_count  = count_q;

`ifdef RF_WR_FWD_EN
  // Bypass compare against the write currently on the port.
  assign fwd_hit  = wr_en && (addr_q == rd_addr) && (rd_addr != '0);
  assign fwd_data = fwd_hit ? data_q : '0;
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
module tb_rf_wr_arbiter;

  localparam int unsigned WD  = 32;
  localparam int unsigned SEL = 5;
  localparam int unsigned CW  = 16;

  logic           clk;
  logic           rst;
  logic           req0_valid, req1_valid;
  logic [SEL-1:0] req0_addr, req1_addr;
  logic [WD-1:0]  req0_data, req1_data;
  logic           req0_ready, req1_ready;
  logic           rf_stall;
  logic           wr_en;
  logic [SEL-1:0] wr_addr;
  logic [WD-1:0]  wr_data;
  logic [WD-1:0]  wr_onehot;
  logic [CW-1:0]  wr_count;
`ifdef RF_WR_FWD_EN
  logic [SEL-1:0] rd_addr;
  logic           fwd_hit;
  logic [WD-1:0]  fwd_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  rf_wr_arbiter #(.WD(WD), .SEL(SEL), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rf_stall   (rf_stall),
`ifdef RF_WR_FWD_EN
    .rd_addr    (rd_addr),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data),
`endif
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_onehot  (wr_onehot),
    .wr_count   (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_port(input string tag, input logic en, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] oh, input logic [31:0] cnt);
    chk({tag, ".wr_en"},     32'(wr_en),     32'(en));
    chk({tag, ".wr_addr"},   32'(wr_addr),   addr);
    chk({tag, ".wr_data"},   wr_data,        data);
    chk({tag, ".wr_onehot"}, wr_onehot,      oh);
    chk({tag, ".wr_count"},  32'(wr_count),  cnt);
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    chk({tag, ".req0_ready"}, 32'(req0_ready), 32'(r0));
    chk({tag, ".req1_ready"}, 32'(req1_ready), 32'(r1));
  endtask

  initial begin
    rst = 1'b1; rf_stall = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
`ifdef RF_WR_FWD_EN
    rd_addr = '0;
`endif

    // Reset state; readies held low by reset even with a valid request.
    step(); step();
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hA5A5_A5A5;
    #1;
    chk_port("reset", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    chk_rdy("reset", 1'b0, 1'b0);

    // Single write to r3.
    rst = 1'b0;
    #1;
    chk_rdy("single.acc", 1'b1, 1'b0);
    step();
    req0_valid = 1'b0;
    chk_port("single.issue", 1'b1, 32'd3, 32'hA5A5_A5A5, 32'h0000_0008, 32'd0);
    step();
    chk_port("single.done", 1'b0, 32'd3, 32'hA5A5_A5A5, 32'h0, 32'd1);

    // Both valid after reset: req0, req1, req0 back-to-back.
    rst = 1'b1; step(); rst = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h0000_0044;
    req1_valid = 1'b1; req1_addr = 5'd5; req1_data = 32'h0000_0055;
    #1;
    chk_rdy("rr.c0", 1'b1, 1'b0);
    step();
    chk_port("rr.w4", 1'b1, 32'd4, 32'h44, 32'h0000_0010, 32'd0);
    req0_addr = 5'd6; req0_data = 32'h0000_0066;
    #1;
    chk_rdy("rr.c1", 1'b0, 1'b1);
    step();
    chk_port("rr.w5", 1'b1, 32'd5, 32'h55, 32'h0000_0020, 32'd1);
    req1_valid = 1'b0;
    #1;
    chk_rdy("rr.c2", 1'b1, 1'b0);
    step();
    chk_port("rr.w6", 1'b1, 32'd6, 32'h66, 32'h0000_0040, 32'd2);
    req0_valid = 1'b0;
    step();
    chk_port("rr.idle", 1'b0, 32'd6, 32'h66, 32'h0, 32'd3);

    // Stall while holding r9; req1 waits until the stall drops.
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h0000_0099;
    #1;
    chk_rdy("stall.acc", 1'b1, 1'b0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'h0000_00AA;
    rf_stall = 1'b1;
    #1;
    chk_rdy("stall.c0", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_port("stall.hold", 1'b1, 32'd9, 32'h99, 32'h0000_0200, 32'd3);
      chk_rdy("stall.hold", 1'b0, 1'b0);
    end
    rf_stall = 1'b0;
    #1;
    chk_rdy("stall.release", 1'b0, 1'b1);
    step();
    req1_valid = 1'b0;
    chk_port("stall.w10", 1'b1, 32'd10, 32'hAA, 32'h0000_0400, 32'd4);
`ifdef RF_WR_FWD_EN
    rd_addr = 5'd10;
    #1;
    chk("fwd.hit", 32'(fwd_hit), 32'd1);
    chk("fwd.data", fwd_data, 32'hAA);
    rd_addr = 5'd11;
    #1;
    chk("fwd.miss", 32'(fwd_hit), 32'd0);
    chk("fwd.miss_data", fwd_data, 32'h0);
`endif
    step();
    chk_port("stall.idle", 1'b0, 32'd10, 32'hAA, 32'h0, 32'd5);

    // Address-0 requests: acknowledged, dropped, pointer still moves.
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h0000_DEAD;
    #1;
    chk_rdy("zero.r1", 1'b0, 1'b1);
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'h0000_BEEF;
    chk_port("zero.after_r1", 1'b0, 32'd10, 32'hAA, 32'h0, 32'd5);
    #1;
    chk_rdy("zero.r0", 1'b1, 1'b0);
    step();
    chk_port("zero.after_r0", 1'b0, 32'd10, 32'hAA, 32'h0, 32'd5);
    // Pointer now favours req1.
    req0_addr = 5'd11; req0_data = 32'h0000_00B1;
    req1_valid = 1'b1; req1_addr = 5'd12; req1_data = 32'h0000_00C1;
    #1;
    chk_rdy("zero.ptr", 1'b0, 1'b1);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0; rf_stall = 1'b1;
    chk_port("zero.w12", 1'b1, 32'd12, 32'hC1, 32'h0000_1000, 32'd5);

    // Reset while stalled in ISSUE discards the held write.
    step();
    rst = 1'b1;
    step();
    chk_port("rst_issue", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    rst = 1'b0; rf_stall = 1'b0;
    step();
    chk_port("rst_issue.after", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);

    // Counter saturation: continuous writes for more than 2^CW cycles.
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h1;
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
    end
    #1;
    chk("sat.count", 32'(wr_count), 32'h0000_FFFF);
    req0_valid = 1'b0;
    step(); step();
    chk("sat.hold", 32'(wr_count), 32'h0000_FFFF);
    chk("sat.idle", 32'(wr_en), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wr_arbiter.md
RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 Parameter WD, default 32 (from RF_my_pkg), SHALL set the write-data and one-hot width.
REQ-002 Parameter SEL, default 5 (from RF_my_pkg), SHALL set the register address width.
REQ-003 Parameter CW, default 16, SHALL set the write-counter width.
REQ-004 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-005 Port rst  in  1: reset, synchronous and active-high.
REQ-006 Ports req0_valid/req1_valid  in  1 each: requester has a pending register write.
REQ-007 Ports req0_addr/req1_addr  in  SEL each: destination register.
REQ-008 Ports req0_data/req1_data  in  WD each: write data.
REQ-009 Ports req0_ready/req1_ready  out  1 each: request accepted this cycle (valid & ready).
REQ-010 Port rf_stall  in  1: register file cannot take a write this cycle.
REQ-011 Port wr_en  out  1: write strobe to the register file.
REQ-012 Port wr_addr  out  SEL: registered write address.
REQ-013 Port wr_data  out  WD: registered write data.
REQ-014 Port wr_onehot  out  WD: decoded wr_addr gated by wr_en; all-zero when wr_en=0 or wr_addr=0.
REQ-015 Port wr_count  out  CW: completed-write counter.

Function
REQ-016 FSM SHALL have two states: IDLE (wr_en=0) and ISSUE (wr_en=1, output register holds one write).
REQ-017 A write SHALL complete in any cycle with state=ISSUE and rf_stall=0.
REQ-018 Acceptance SHALL be possible when state=IDLE, or ISSUE with completion that cycle; otherwise both readies are 0.
REQ-019 Only one requester SHALL be accepted per cycle; at most one ready is 1.
REQ-020 Single valid requester SHALL be granted; when both are valid, the round-robin pointer's favoured requester wins.
REQ-021 Pointer SHALL move to the other requester after every acceptance; the losing requester therefore wins next eligible cycle.
REQ-022 Accepted request with nonzero address SHALL load wr_addr/wr_data and enter/remain in ISSUE the next cycle (1-cycle latency, 1 write/cycle throughput).
REQ-023 Accepted request with address 0 SHALL be acknowledged but discarded: no ISSUE, wr_count unchanged, pointer still advances.
REQ-024 Completion with no new nonzero acceptance SHALL return to IDLE; stall in ISSUE SHALL hold all outputs unchanged.
REQ-025 wr_count SHALL increment by 1 per completed write and saturate at all-ones.
REQ-026 Same-address requests in one cycle SHALL issue in grant order; the loser's data is the final register value.
REQ-027 Readies SHALL be combinational from valid, state, rf_stall and pointer; no dependency on the requester's sampling of ready.

Reset
REQ-028 rst SHALL force state=IDLE, wr_en=0, wr_addr=0, wr_data=0, wr_onehot=0, wr_count=0, pointer favouring req0, both readies 0.
REQ-029 rst during ISSUE SHALL discard the held write; no write issued the cycle after reset.

Configuration
REQ-030 Macro RF_WR_FWD_EN defined SHALL add ports rd_addr (in, SEL), fwd_hit (out, 1), fwd_data (out, WD): fwd_hit=1 when wr_en=1 and wr_addr=rd_addr and rd_addr!=0; fwd_data=wr_data when hit, else 0.
REQ-031 Without RF_WR_FWD_EN those ports and the comparison logic SHALL be absent; all other behaviour identical.

Structure
REQ-032 SEL, WD and the state enum type (IDLE, ISSUE) SHALL live in RF_my_pkg.
REQ-033 Arbitration SHALL be a sub-module rf_rr_arb (2 valids + pointer in, 2 grants out, pointer update).

Verification
REQ-034 req0 valid addr=3 data=0xA5A5A5A5, no stall -> req0_ready same cycle; next cycle wr_en=1, wr_addr=3, wr_onehot=0x00000008, then wr_count=1.
REQ-035 Both valid, addr 4 and 5, after reset -> req0 first, req1 next cycle; writes issue back-to-back, pointer alternates.
REQ-036 ISSUE with rf_stall=1 for 3 cycles, req1 valid -> outputs frozen, req1_ready=0; stall drop -> completion, req1 accepted same cycle.
REQ-037 req1 addr=0 -> req1_ready=1, wr_en stays 0, wr_count unchanged.
REQ-038 rst asserted while ISSUE stalled -> next cycle all outputs at reset values, no write issued.
REQ-039 With RF_WR_FWD_EN, wr_addr=7 issuing, rd_addr=7 -> fwd_hit=1, fwd_data=wr_data; rd_addr=0 -> fwd_hit=0.
